// File: rtl/freq_bcd_if.sv
// Bus between frequency finder/display and freq_bcd_converter: binary word in, BCD readout out.
interface freq_bcd_if #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned DIGITS = 10
);
  logic [IN_W-1:0]     freq_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [3:0]          num_digits;
  logic                digits_valid;
  logic                busy;

  modport master (
    output freq_in,
    input  bcd_out,
    input  num_digits,
    input  digits_valid,
    input  busy
  );

  modport slave (
    input  freq_in,
    output bcd_out,
    output num_digits,
    output digits_valid,
    output busy
  );
endinterface

// File: rtl/freq_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, retriggered whenever freq_in changes.
// Optional FREQ_BCD_BLANK_EN replaces leading zero digits with 4'hF.
module freq_bcd_converter #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned DIGITS = 10
) (
  input logic        clk,
  input logic        rst_n,
  freq_bcd_if.slave  bus
);
  localparam int unsigned BcdW = 4 * DIGITS;
`ifdef FREQ_BCD_BLANK_EN
  localparam logic [BcdW-1:0] BcdRst = {{(BcdW-4){1'b1}}, 4'h0};
`else
  localparam logic [BcdW-1:0] BcdRst = '0;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   last_q, last_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [3:0]        nd_q, nd_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [BcdW-1:0]   adj;
  logic [3:0]        nd_calc;
  logic [BcdW-1:0]   bcd_fmt;

  // Add-3 per nibble; a corrected nibble stays <= 4'hC, so no carry crosses digits.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    nd_calc = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] != 4'd0) nd_calc = 4'(i + 1);
    end
  end

  always_comb begin
    bcd_fmt = work_q;
`ifdef FREQ_BCD_BLANK_EN
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(nd_calc)) bcd_fmt[4*i +: 4] = 4'hF;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    nd_d    = nd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (bus.freq_in != last_q) begin
          shreg_d = bus.freq_in;
          last_d  = bus.freq_in;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        {work_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(IN_W - 1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = bcd_fmt;
        nd_d    = nd_calc;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= '0;
      shreg_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= BcdRst;
      nd_q    <= 4'd1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      nd_q    <= nd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.bcd_out      = bcd_q;
  assign bus.num_digits   = nd_q;
  assign bus.digits_valid = valid_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_freq_bcd_converter.sv
// Scoreboard bench for freq_bcd_converter: decimal reference model, decoupled strobe monitor.
module tb_freq_bcd_converter;
`ifdef FREQ_BCD_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  nd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_push = 0;
  int   n_strobe = 0;
  logic [31:0] tb_last = '0;
  exp_t exp_q[$];
  exp_t mon_e;

  freq_bcd_if bus ();

  freq_bcd_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_nd(longint unsigned v);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [39:0] ref_bcd(longint unsigned v);
    logic [39:0] r = '0;
    int nd = ref_nd(v);
    longint unsigned t = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = (Blank && i >= nd) ? 4'hF : 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] v, input int when);
    exp_t e;
    e.bcd = ref_bcd(v);
    e.nd  = 4'(ref_nd(v));
    e.cyc = when;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Drive at a falling edge; the capture edge is the next rising edge.
  task automatic apply(input logic [31:0] v);
    @(negedge clk);
    bus.freq_in = v;
    if (v != tb_last) begin
      push_exp(v, cyc + 34);
      tb_last = v;
      @(negedge clk);
      check("busy_after_capture", 64'(bus.busy), 64'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL strobe_timeout: got no strobe, expected %0d pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.digits_valid === 1'b1) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got bcd %h nd %0d, expected no strobe (cycle %0d)",
                 bus.bcd_out, bus.num_digits, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("bcd_out", 64'(bus.bcd_out), 64'(mon_e.bcd));
        check("num_digits", 64'(bus.num_digits), 64'(mon_e.nd));
        check("busy_at_strobe", 64'(bus.busy), 64'd0);
        if (mon_e.cyc >= 0) check("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int sel;
    logic [31:0] v;
    bus.freq_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 64'(bus.bcd_out), 64'(ref_bcd(0)));
    check("rst_nd", 64'(bus.num_digits), 64'd1);
    check("rst_valid", 64'(bus.digits_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;

    // Zero input after reset must stay silent.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
    end
    check("idle_bcd", 64'(bus.bcd_out), 64'(ref_bcd(0)));
    check("idle_nd", 64'(bus.num_digits), 64'd1);

    apply(32'd1234);
    drain();
    apply(32'hFFFF_FFFF);
    drain();

    // Changes while busy: 50 dropped, 75 converted right after the first strobe.
    apply(32'd100000);
    c = exp_q[0].cyc - 34;
    repeat (4) @(negedge clk);
    bus.freq_in = 32'd50;
    repeat (5) @(negedge clk);
    bus.freq_in = 32'd75;
    push_exp(32'd75, c + 68);
    tb_last = 32'd75;
    drain();

    // Reset mid-conversion aborts; the value is reconverted after release.
    @(negedge clk);
    bus.freq_in = 32'd999999999;
    tb_last = 32'd999999999;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_bcd", 64'(bus.bcd_out), 64'(ref_bcd(0)));
    check("abort_nd", 64'(bus.num_digits), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'd999999999, cyc + 34);
    drain();

    apply(32'd1234);
    drain();
    apply(32'd1234);
    repeat (50) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 9));
        2: v = 32'($urandom_range(0, 99999));
        default: v = tb_last;
      endcase
      apply(v);
      drain();
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    check("strobe_count", 64'(n_strobe), 64'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
